cache_mem_arbiter: RTL and testbench

Sequences and shares the single pipelined main memory between the instruction-cache miss handler and the data-cache miss/write-through path. D-side requests normally win. On a simultaneous I/D request the grant alternates so neither side starves. A granted fill issues one word address per cycle for a full cache block and returns words to the requester as the memory pipeline delivers them. Sits between both cache controllers and the 4-cycle memory module in the pipelined CPU.

---
 rtl/cache_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one pipelined memory between I-cache fills and D-cache fills/writes.
// Latency: first mem_en 1 cycle after grant; fill words return MEM_LAT after issue.
// Backpressure: requests are level-held and only considered in IDLE; no stalls once granted.
module cache_mem_arbiter #(
   parameter int WORDS   = 8,
   parameter int MEM_LAT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_req,
   input  logic [15:0]              i_addr,
   input  logic                     d_req,
   input  logic                     d_wr,
   input  logic [15:0]              d_addr,
   input  logic [15:0]              d_wdata,
   input  logic [15:0]              mem_rdata,
   output logic                     mem_en,
   output logic                     mem_wr,
   output logic [15:0]              mem_addr,
   output logic [15:0]              mem_wdata,
   output logic [15:0]              fill_data,
   output logic [$clog2(WORDS)-1:0] fill_idx,
   output logic                     i_fill_valid,
   output logic                     d_fill_valid,
   output logic                     i_done,
   output logic                     d_done,
   output logic                     busy
);
   localparam int IW = $clog2(WORDS);
   localparam logic [IW:0]   NW   = (IW+1)'(WORDS);
   localparam logic [IW-1:0] LAST = '1;

   typedef enum logic [1:0] {IDLE, WRITE, FILL, GAP} state_t;

   state_t         state;
   logic           last_d;      // last grant, also selects the side of the active transaction
   logic [IW:0]    iss_cnt;
   logic [14-IW:0] fill_base;

   logic [MEM_LAT-1:0] pv;
   logic [IW-1:0]      pidx [MEM_LAT];

   logic           pick_d;
   logic [14-IW:0] pick_base;
   logic           ret_vld;
   logic [IW-1:0]  ret_idx;
   logic           ret_last;
   logic           unused_addr_lsbs;

   // Tie-break alternates: D wins unless it was granted last
   assign pick_d    = d_req & (~i_req | ~last_d);
   assign pick_base = pick_d ? d_addr[15:IW+1] : i_addr[15:IW+1];
   assign unused_addr_lsbs = ^i_addr[IW:0];

   assign ret_vld  = pv[MEM_LAT-1];
   assign ret_idx  = pidx[MEM_LAT-1];
   assign ret_last = ret_vld && (ret_idx == LAST);

   assign fill_data    = ret_vld ? mem_rdata : '0;
   assign fill_idx     = ret_vld ? ret_idx : '0;
   assign i_fill_valid = ret_vld & ~last_d;
   assign d_fill_valid = ret_vld & last_d;
   assign i_done       = ret_last & ~last_d;
   assign d_done       = (state == WRITE) | (ret_last & last_d);
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         iss_cnt   <= '0;
         fill_base <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         pv        <= '0;
         for (int i = 0; i < MEM_LAT; i++) pidx[i] <= '0;
      end else begin
         // Return tracker: each issued read word reappears MEM_LAT cycles later
         for (int i = MEM_LAT-1; i > 0; i--) begin
            pv[i]   <= pv[i-1];
            pidx[i] <= pidx[i-1];
         end
         pv[0]   <= (state == FILL) && mem_en;
         pidx[0] <= mem_addr[IW:1];

         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;

         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  last_d <= pick_d;
                  if (pick_d && d_wr) begin
                     state     <= WRITE;
                     mem_en    <= 1'b1;
                     mem_wr    <= 1'b1;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     state     <= FILL;
                     fill_base <= pick_base;
                     mem_en    <= 1'b1;
                     mem_addr  <= {pick_base, {IW{1'b0}}, 1'b0};
                     iss_cnt   <= {{IW{1'b0}}, 1'b1};
                  end
               end
            end
            WRITE: state <= GAP;
            FILL: begin
               if (iss_cnt < NW) begin
                  mem_en   <= 1'b1;
                  mem_addr <= {fill_base, iss_cnt[IW-1:0], 1'b0};
                  iss_cnt  <= iss_cnt + 1'b1;
               end
               if (ret_last) state <= GAP;
            end
            GAP: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: schedule-table model plus directed literal checks.
module tb_cache_mem_arbiter;
   localparam int WORDS   = 8;
   localparam int MEM_LAT = 4;
   localparam int IW      = 3;
   localparam int NC      = 256;

   logic        clk;
   logic        rst;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, fill_data;
   logic [IW-1:0] fill_idx;
   logic        i_fill_valid, d_fill_valid, i_done, d_done, busy;

   cache_mem_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .mem_rdata(mem_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .fill_data(fill_data), .fill_idx(fill_idx),
      .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
      .i_done(i_done), .d_done(d_done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;

   // Memory contents: each word holds the inverted byte address of the word
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return ~{a[15:1], 1'b0};
   endfunction

   bit [MEM_LAT-1:0] rv;
   bit [15:0]        rd [MEM_LAT];
   always @(posedge clk) begin
      for (int j = MEM_LAT-1; j > 0; j--) begin
         rv[j] <= rv[j-1];
         rd[j] <= rd[j-1];
      end
      rv[0] <= mem_en && !mem_wr;
      rd[0] <= mem_word(mem_addr);
   end
   assign mem_rdata = rv[MEM_LAT-1] ? rd[MEM_LAT-1] : 16'hDEAD;

   // Expected outputs per cycle, filled in when the model grants a transaction
   bit        e_en [NC];
   bit        e_wr [NC];
   bit [15:0] e_addr [NC];
   bit [15:0] e_wdata [NC];
   bit [15:0] e_fdata [NC];
   bit [IW-1:0] e_idx [NC];
   bit        e_ifv [NC];
   bit        e_dfv [NC];
   bit        e_idone [NC];
   bit        e_ddone [NC];
   bit        e_busy [NC];

   int m_idle_from = 0;
   bit m_last_d    = 1'b0;
   bit m_sd;

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, exp);
      end
   endtask

   task automatic clear_from(input int c);
      for (int j = c; j < NC; j++) begin
         e_en[j] = 0; e_wr[j] = 0; e_addr[j] = 0; e_wdata[j] = 0; e_fdata[j] = 0;
         e_idx[j] = 0; e_ifv[j] = 0; e_dfv[j] = 0; e_idone[j] = 0; e_ddone[j] = 0; e_busy[j] = 0;
      end
   endtask

   task automatic sched(input int c, input bit sd, input bit wr, input logic [15:0] a, input logic [15:0] wd);
      logic [15:0] base;
      int r;
      if (wr) begin
         e_en[c+1] = 1; e_wr[c+1] = 1; e_addr[c+1] = a; e_wdata[c+1] = wd;
         e_ddone[c+1] = 1; e_busy[c+1] = 1; e_busy[c+2] = 1;
         m_idle_from = c + 3;
      end else begin
         base = a & ~16'(2*WORDS-1);
         for (int k = 0; k < WORDS; k++) begin
            e_en[c+1+k]   = 1;
            e_addr[c+1+k] = base + 16'(2*k);
            r = c + 1 + k + MEM_LAT;
            if (sd) e_dfv[r] = 1; else e_ifv[r] = 1;
            e_idx[r]   = IW'(k);
            e_fdata[r] = mem_word(base + 16'(2*k));
         end
         if (sd) e_ddone[c+WORDS+MEM_LAT] = 1; else e_idone[c+WORDS+MEM_LAT] = 1;
         for (int j = c+1; j <= c+WORDS+MEM_LAT+1; j++) e_busy[j] = 1;
         m_idle_from = c + WORDS + MEM_LAT + 2;
      end
      m_last_d = sd;
   endtask

   always @(negedge clk) begin
      if (cyc >= 1 && cyc < NC-32) begin
         if (!rst && cyc >= m_idle_from && (i_req || d_req)) begin
            m_sd = d_req && (!i_req || !m_last_d);
            sched(cyc, m_sd, m_sd && d_wr, m_sd ? d_addr : i_addr, d_wdata);
         end
         chk("mem_en",       cyc, mem_en,       e_en[cyc]);
         chk("mem_wr",       cyc, mem_wr,       e_wr[cyc]);
         chk("mem_addr",     cyc, mem_addr,     e_addr[cyc]);
         chk("mem_wdata",    cyc, mem_wdata,    e_wdata[cyc]);
         chk("fill_data",    cyc, fill_data,    e_fdata[cyc]);
         chk("fill_idx",     cyc, fill_idx,     e_idx[cyc]);
         chk("i_fill_valid", cyc, i_fill_valid, e_ifv[cyc]);
         chk("d_fill_valid", cyc, d_fill_valid, e_dfv[cyc]);
         chk("i_done",       cyc, i_done,       e_idone[cyc]);
         chk("d_done",       cyc, d_done,       e_ddone[cyc]);
         chk("busy",         cyc, busy,         e_busy[cyc]);
         if (rst) begin
            clear_from(cyc + 1);
            m_idle_from = cyc + 1;
            m_last_d    = 1'b0;
         end
      end
   end

   task automatic go_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sample();
      #3;
   endtask

   task automatic wait_done(input bit side_d, input int limit, output int at);
      at = -1;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (side_d ? d_done : i_done) begin
            at = cyc;
            break;
         end
      end
   endtask

   int at;

   initial begin
      rst = 1; i_req = 1; d_req = 1; d_wr = 0;
      i_addr = 16'h123A; d_addr = 16'h0310; d_wdata = 16'h0000;

      // Reset held with both requests pending
      go_to(1); sample();
      chk("rst_busy", cyc, busy, 0);
      chk("rst_mem_en", cyc, mem_en, 0);
      go_to(2); sample();
      chk("rst_done", cyc, {i_done, d_done}, 0);
      go_to(3); rst = 0;

      // Contention: D, I, D, I
      go_to(4); sample();
      chk("tie1_d_addr", cyc, mem_addr, 16'h0310);
      wait_done(1, 30, at);
      chk("tie1_d_done_cyc", cyc, at, 15);
      go_to(16); d_req = 0;
      go_to(17); d_req = 1;
      go_to(18); sample();
      chk("tie2_i_addr", cyc, mem_addr, 16'h1230);
      wait_done(0, 30, at);
      chk("tie2_i_done_cyc", cyc, at, 29);
      go_to(30); i_req = 0;
      go_to(31); i_req = 1;
      go_to(32); sample();
      chk("tie3_d_addr", cyc, mem_addr, 16'h0310);
      wait_done(1, 30, at);
      chk("tie3_d_done_cyc", cyc, at, 43);
      go_to(44); d_req = 0;
      wait_done(0, 30, at);
      chk("tie4_i_done_cyc", cyc, at, 57);
      go_to(58); i_req = 0;

      // Single-word D write
      go_to(60); d_req = 1; d_wr = 1; d_addr = 16'h0042; d_wdata = 16'hBEEF;
      go_to(61); sample();
      chk("wr_en_wr", cyc, {mem_en, mem_wr}, 2'b11);
      chk("wr_addr", cyc, mem_addr, 16'h0042);
      chk("wr_wdata", cyc, mem_wdata, 16'hBEEF);
      chk("wr_done", cyc, d_done, 1);
      go_to(62); d_req = 0; d_wr = 0; sample();
      chk("wr_gap_busy", cyc, busy, 1);
      chk("wr_gap_mem_en", cyc, mem_en, 0);
      go_to(63); sample();
      chk("wr_idle_busy", cyc, busy, 0);

      // I fill with a D request arriving mid-transaction
      go_to(64); i_req = 1; i_addr = 16'h123A;
      go_to(67); d_req = 1; d_addr = 16'h0A5E;
      go_to(69); sample();
      chk("ifill_first_vld", cyc, {i_fill_valid, d_fill_valid, mem_en}, 3'b101);
      chk("ifill_first_idx", cyc, fill_idx, 0);
      chk("ifill_first_data", cyc, fill_data, 16'hEDCF);
      go_to(76); sample();
      chk("ifill_last_done", cyc, {i_done, d_done}, 2'b10);
      chk("ifill_last_idx", cyc, fill_idx, 7);
      chk("ifill_last_data", cyc, fill_data, 16'hEDC1);
      go_to(77); i_req = 0;
      go_to(78); sample();
      chk("late_d_not_yet", cyc, mem_en, 0);
      go_to(79); sample();
      chk("late_d_addr", cyc, {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0A50});
      wait_done(1, 30, at);
      chk("late_d_done_cyc", cyc, at, 90);
      go_to(91); d_req = 0;

      // Reset in the middle of a D fill
      go_to(94); d_req = 1; d_addr = 16'h2000;
      go_to(100); rst = 1; d_req = 0;
      go_to(101); rst = 0;
      for (int c = 101; c <= 106; c++) begin
         go_to(c); sample();
         chk("rst_mid_quiet", cyc, {d_fill_valid, d_done, mem_en, fill_data}, 19'd0);
      end
      go_to(107); i_req = 1; i_addr = 16'h4008;
      go_to(108); sample();
      chk("post_rst_i_addr", cyc, mem_addr, 16'h4000);
      wait_done(0, 30, at);
      chk("post_rst_i_done_cyc", cyc, at, 119);
      go_to(120); i_req = 0;

      go_to(125);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
